// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing generator: FSM encoding, standard mode constants
// and the line/frame total helper.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // 640x480 @ 60 Hz, 25 MHz pixel clock
  localparam int unsigned M640_H_DISP  = 640;
  localparam int unsigned M640_H_FP    = 16;
  localparam int unsigned M640_H_PULSE = 96;
  localparam int unsigned M640_H_BP    = 48;
  localparam int unsigned M640_V_DISP  = 480;
  localparam int unsigned M640_V_FP    = 10;
  localparam int unsigned M640_V_PULSE = 2;
  localparam int unsigned M640_V_BP    = 33;
  localparam int unsigned M640_CNT_W   = 10;

  // 800x600 @ 60 Hz, 40 MHz pixel clock
  localparam int unsigned M800_H_DISP  = 800;
  localparam int unsigned M800_H_FP    = 40;
  localparam int unsigned M800_H_PULSE = 128;
  localparam int unsigned M800_H_BP    = 88;
  localparam int unsigned M800_V_DISP  = 600;
  localparam int unsigned M800_V_FP    = 1;
  localparam int unsigned M800_V_PULSE = 4;
  localparam int unsigned M800_V_BP    = 23;
  localparam int unsigned M800_CNT_W   = 11;

  function automatic int unsigned total_count(input int unsigned disp, input int unsigned fp,
                                              input int unsigned pulse, input int unsigned bp);
    return disp + fp + pulse + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): wrapping position counter plus a registered
// "at last position" flag and lookahead decodes of the next position for the top to register.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned DISP  = 640,
  parameter int unsigned FP    = 16,
  parameter int unsigned PULSE = 96,
  parameter int unsigned BP    = 48,
  parameter int unsigned POL   = 0,
  parameter int unsigned CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_advance,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count,
  output logic             o_wrap,
  output logic             o_active_c,
  output logic             o_sync_c
);

  localparam int unsigned      TOTAL    = total_count(DISP, FP, PULSE, BP);
  localparam int unsigned      SYNC_BEG = DISP + FP;
  localparam int unsigned      SYNC_END = DISP + FP + PULSE;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  // Decodes use the next count so the top can register them alongside the counter.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_advance) begin
      count_d = wrap_q ? '0 : count_q + CNT_W'(1);
    end
    wrap_d     = (count_d == LAST);
    o_active_c = (32'(count_d) < DISP);
    o_sync_c   = ((32'(count_d) >= SYNC_BEG) && (32'(count_d) < SYNC_END)) ? 1'(POL) : ~1'(POL);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      count_q <= '0;
      wrap_q  <= (LAST == '0);
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_count = count_q;
  assign o_wrap  = wrap_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel clock-enable and a run/stop FSM that only
// stops at frame boundaries. Optional o_frame_cnt output under VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISP  = M640_H_DISP,
  parameter int unsigned H_FP    = M640_H_FP,
  parameter int unsigned H_PULSE = M640_H_PULSE,
  parameter int unsigned H_BP    = M640_H_BP,
  parameter int unsigned V_DISP  = M640_V_DISP,
  parameter int unsigned V_FP    = M640_V_FP,
  parameter int unsigned V_PULSE = M640_V_PULSE,
  parameter int unsigned V_BP    = M640_V_BP,
  parameter int unsigned H_POL   = 0,
  parameter int unsigned V_POL   = 0,
  parameter int unsigned CNT_W   = M640_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_pix_ce,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_x_counter,
  output logic [CNT_W-1:0] o_y_counter,
  output logic             o_video,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_sof,
  output logic             o_sol,
  output logic             o_busy
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      o_frame_cnt
`endif
);

  localparam logic HSYNC_OFF = ~1'(H_POL);
  localparam logic VSYNC_OFF = ~1'(V_POL);

  state_e state_q, state_d;
  logic   video_q, video_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   sof_q, sof_d;
  logic   sol_q, sol_d;
  logic   busy_q, busy_d;

  logic h_adv, v_adv, cnt_clear, frame_end;
  logic h_wrap, v_wrap, h_active_c, v_active_c, h_sync_c, v_sync_c;

  assign h_adv     = i_pix_ce && (state_q != ST_IDLE);
  assign v_adv     = h_adv && h_wrap;
  assign cnt_clear = (state_q == ST_IDLE);
  assign frame_end = h_wrap && v_wrap;

  vga_axis_counter #(
    .DISP(H_DISP), .FP(H_FP), .PULSE(H_PULSE), .BP(H_BP), .POL(H_POL), .CNT_W(CNT_W)
  ) u_h_axis (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_advance  (h_adv),
    .i_clear    (cnt_clear),
    .o_count    (o_x_counter),
    .o_wrap     (h_wrap),
    .o_active_c (h_active_c),
    .o_sync_c   (h_sync_c)
  );

  vga_axis_counter #(
    .DISP(V_DISP), .FP(V_FP), .PULSE(V_PULSE), .BP(V_BP), .POL(V_POL), .CNT_W(CNT_W)
  ) u_v_axis (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_advance  (v_adv),
    .i_clear    (cnt_clear),
    .o_count    (o_y_counter),
    .o_wrap     (v_wrap),
    .o_active_c (v_active_c),
    .o_sync_c   (v_sync_c)
  );

  // Next state and strobes; a DRAIN that reaches the frame end with i_en low parks in IDLE.
  always_comb begin
    state_d = state_q;
    sof_d   = 1'b0;
    sol_d   = 1'b0;
    if (i_pix_ce) begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_en) begin
            state_d = ST_RUN;
            sof_d   = 1'b1;
            sol_d   = 1'b1;
          end
        end
        ST_RUN: begin
          sol_d = h_wrap;
          sof_d = frame_end;
          if (!i_en) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (i_en) begin
            state_d = ST_RUN;
            sol_d   = h_wrap;
            sof_d   = frame_end;
          end else if (frame_end) begin
            state_d = ST_IDLE;
          end else begin
            sol_d = h_wrap;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d  = (state_d != ST_IDLE);
    video_d = busy_d && h_active_c && v_active_c;
    hsync_d = busy_d ? h_sync_c : HSYNC_OFF;
    vsync_d = busy_d ? v_sync_c : VSYNC_OFF;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      video_q <= 1'b0;
      hsync_q <= HSYNC_OFF;
      vsync_q <= VSYNC_OFF;
      sof_q   <= 1'b0;
      sol_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      video_q <= video_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      sof_q   <= sof_d;
      sol_q   <= sol_d;
      busy_q  <= busy_d;
    end
  end

  assign o_video = video_q;
  assign o_hsync = hsync_q;
  assign o_vsync = vsync_q;
  assign o_sof   = sof_q;
  assign o_sol   = sol_q;
  assign o_busy  = busy_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (sof_d) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) frame_cnt_q <= 16'd0;
    else         frame_cnt_q <= frame_cnt_d;
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small mode; a behavioural model queues the expected
// outputs of every cycle and they are compared after the clock edge.
module tb_vga_timing_gen;

  localparam int unsigned HD = 8, HF = 2, HP = 3, HB = 2;
  localparam int unsigned VD = 4, VF = 1, VP = 2, VB = 1;
  localparam int unsigned HPOL = 0, VPOL = 1, CW = 4;
  localparam int unsigned HT = HD + HF + HP + HB;
  localparam int unsigned VT = VD + VF + VP + VB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_rstn, i_pix_ce, i_en;
  logic [CW-1:0] o_x_counter, o_y_counter;
  logic          o_video, o_hsync, o_vsync, o_sof, o_sol, o_busy;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]   o_frame_cnt;
`endif

  vga_timing_gen #(
    .H_DISP(HD), .H_FP(HF), .H_PULSE(HP), .H_BP(HB),
    .V_DISP(VD), .V_FP(VF), .V_PULSE(VP), .V_BP(VB),
    .H_POL(HPOL), .V_POL(VPOL), .CNT_W(CW)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (i_rstn),
    .i_pix_ce    (i_pix_ce),
    .i_en        (i_en),
    .o_x_counter (o_x_counter),
    .o_y_counter (o_y_counter),
    .o_video     (o_video),
    .o_hsync     (o_hsync),
    .o_vsync     (o_vsync),
    .o_sof       (o_sof),
    .o_sol       (o_sol),
    .o_busy      (o_busy)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .o_frame_cnt (o_frame_cnt)
`endif
  );

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          video;
    logic          hsync;
    logic          vsync;
    logic          sof;
    logic          sol;
    logic          busy;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]   fcnt;
`endif
  } obs_t;

  obs_t        exp_q[$];
  obs_t        last_obs;
  int          checks = 0;
  int          errors = 0;
  int          ms = 0;
  int unsigned mx = 0, my = 0;
  logic        msof = 1'b0, msol = 1'b0;
  logic [15:0] mfcnt = 16'd0;
  int          cnt_video, cnt_hs, cnt_vs, cnt_sof, cnt_sol, cnt_idle;

  task automatic clear_stats();
    cnt_video = 0; cnt_hs = 0; cnt_vs = 0; cnt_sof = 0; cnt_sol = 0; cnt_idle = 0;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, queue its expectation, then compare.
  task automatic step(input logic rstn, input logic en, input logic ce);
    obs_t e, o;
    logic endf, going_idle;
    i_rstn = rstn; i_en = en; i_pix_ce = ce;
    if (!rstn) begin
      ms = 0; mx = 0; my = 0; msof = 1'b0; msol = 1'b0; mfcnt = 16'd0;
    end else if (!ce) begin
      msof = 1'b0; msol = 1'b0;
    end else if (ms == 0) begin
      msof = en; msol = en;
      if (en) ms = 1;
    end else begin
      endf       = (mx == HT - 1) && (my == VT - 1);
      going_idle = (ms == 2) && !en && endf;
      msol       = (mx == HT - 1) && !going_idle;
      msof       = endf && !going_idle;
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      ms = going_idle ? 0 : (en ? 1 : 2);
    end
    if (msof) mfcnt = mfcnt + 16'd1;
    e.x     = CW'(mx);
    e.y     = CW'(my);
    e.video = (ms != 0) && (mx < HD) && (my < VD);
    e.hsync = ((ms != 0) && (mx >= HD + HF) && (mx < HD + HF + HP)) ? 1'(HPOL) : ~1'(HPOL);
    e.vsync = ((ms != 0) && (my >= VD + VF) && (my < VD + VF + VP)) ? 1'(VPOL) : ~1'(VPOL);
    e.sof   = msof;
    e.sol   = msol;
    e.busy  = (ms != 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    e.fcnt  = mfcnt;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.x = o_x_counter; o.y = o_y_counter; o.video = o_video; o.hsync = o_hsync;
    o.vsync = o_vsync; o.sof = o_sof; o.sol = o_sol; o.busy = o_busy;
`ifdef VGA_TIMING_FRAME_CNT_EN
    o.fcnt = o_frame_cnt;
`endif
    e = exp_q.pop_front();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL outputs t=%0t observed=%h expected=%h", $time, o, e);
    end
    last_obs  = o;
    cnt_video += int'(o.video);
    cnt_hs    += int'(o.hsync == 1'(HPOL));
    cnt_vs    += int'(o.vsync == 1'(VPOL));
    cnt_sof   += int'(o.sof);
    cnt_sol   += int'(o.sol);
    cnt_idle  += int'(!o.busy);
  endtask

  task automatic walk_to(input int unsigned tx, input int unsigned ty, input logic en);
    int n = 0;
    while (!(mx == tx && my == ty) && n < int'(4 * HT * VT)) begin
      step(1'b1, en, 1'b1);
      n++;
    end
  endtask

  initial begin
    i_rstn = 1'b0; i_en = 1'b0; i_pix_ce = 1'b0;
    clear_stats();

    // Reset dominates a run request
    repeat (3) step(1'b0, 1'b1, 1'b1);
    check("reset_busy", int'(last_obs.busy), 0);
    check("reset_hsync_inactive", int'(last_obs.hsync), 1);

    // One full frame at full rate
    clear_stats();
    step(1'b1, 1'b1, 1'b1);
    check("start_sof", int'(last_obs.sof), 1);
    repeat (HT * VT - 1) step(1'b1, 1'b1, 1'b1);
    check("video_per_frame", cnt_video, int'(HD * VD));
    check("hsync_per_frame", cnt_hs, int'(HP * VT));
    check("vsync_per_frame", cnt_vs, int'(VP * HT));
    check("sof_per_frame", cnt_sof, 1);
    step(1'b1, 1'b1, 1'b1);
    check("sof_period", int'(last_obs.sof), 1);

    // Half-rate pixel enable
    clear_stats();
    for (int i = 0; i < int'(2 * HT * VT); i++) step(1'b1, 1'b1, 1'((i % 2) == 1));
    check("half_rate_sof", cnt_sof, 1);
    check("half_rate_sol", cnt_sol, int'(VT));
    check("half_rate_video", cnt_video, int'(2 * HD * VD));
    check("half_rate_end_sof", int'(last_obs.sof), 1);

    // Stop request mid-frame: frame completes, parks at (0,0) without a strobe
    walk_to(3, 2, 1'b1);
    clear_stats();
    begin
      int n = 0;
      step(1'b1, 1'b0, 1'b1);
      while (ms != 0 && n < int'(2 * HT * VT)) begin
        step(1'b1, 1'b0, 1'b1);
        n++;
      end
    end
    check("drain_busy", int'(last_obs.busy), 0);
    check("drain_x", int'(last_obs.x), 0);
    check("drain_y", int'(last_obs.y), 0);
    check("drain_no_sof", cnt_sof, 0);

    // Re-enable during DRAIN: no gap, normal wrap with o_sof
    step(1'b1, 1'b1, 1'b1);
    walk_to(2, 1, 1'b1);
    walk_to(5, VD - 1, 1'b0);
    clear_stats();
    step(1'b1, 1'b1, 1'b1);
    walk_to(0, 0, 1'b1);
    check("resume_sof", int'(last_obs.sof), 1);
    check("resume_busy", int'(last_obs.busy), 1);
    check("resume_no_gap", cnt_idle, 0);

    // Mid-frame reset and restart
    walk_to(6, 5, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("midreset_busy", int'(last_obs.busy), 0);
    check("midreset_x", int'(last_obs.x), 0);
    check("midreset_vsync_inactive", int'(last_obs.vsync), 0);
    step(1'b1, 1'b1, 1'b1);
    check("restart_sof", int'(last_obs.sof), 1);

`ifdef VGA_TIMING_FRAME_CNT_EN
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    repeat (2 * HT * VT) step(1'b1, 1'b1, 1'b1);
    check("frame_cnt_3", int'(o_frame_cnt), 3);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    mfcnt = 16'hFFFF;
    walk_to(0, 0, 1'b1);
    check("frame_cnt_wrap", int'(o_frame_cnt), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
